// File: rtl/ysyx_24100029_bhr_spec.sv
// Local branch-history table holding a speculative and an architectural copy per entry.
// Define BHR_SPEC_BYPASS_EN to forward same-cycle spec updates and flush state onto the read ports.
module ysyx_24100029_bhr_spec #(
   parameter int HIST_WIDTH  = 3,
   parameter int INDEX_WIDTH = 3,
   parameter int NUM_RD      = 2
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_RD*INDEX_WIDTH-1:0]    rd_index,
   output logic [NUM_RD*HIST_WIDTH-1:0]     rd_value,
   input  logic                             spec_en,
   input  logic [INDEX_WIDTH-1:0]           spec_index,
   input  logic                             spec_taken,
   input  logic                             cmt_en,
   input  logic [INDEX_WIDTH-1:0]           cmt_index,
   input  logic                             cmt_taken,
   input  logic                             flush,
   output logic [(1<<INDEX_WIDTH)-1:0]      diverged
);

   localparam int ENTRIES = 1 << INDEX_WIDTH;

   typedef logic [HIST_WIDTH-1:0] hist_t;

   // Newest outcome lands in bit 0; also correct for a 1-bit history.
   function automatic hist_t shift_in(input hist_t old, input logic b);
      return (old << 1) | hist_t'(b);
   endfunction

   hist_t spec_reg  [ENTRIES];
   hist_t arch_reg  [ENTRIES];
   hist_t arch_next [ENTRIES];

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         assign arch_next[gi] = (cmt_en && cmt_index == INDEX_WIDTH'(gi))
                                ? shift_in(arch_reg[gi], cmt_taken) : arch_reg[gi];

         // A flush squashes any same-cycle speculative update.
         always_ff @(posedge clock) begin
            if (reset) begin
               arch_reg[gi] <= '0;
               spec_reg[gi] <= '0;
            end else begin
               arch_reg[gi] <= arch_next[gi];
               if (flush)
                  spec_reg[gi] <= arch_next[gi];
               else if (spec_en && spec_index == INDEX_WIDTH'(gi))
                  spec_reg[gi] <= shift_in(spec_reg[gi], spec_taken);
            end
         end

         assign diverged[gi] = (spec_reg[gi] != arch_reg[gi]);
      end

      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [INDEX_WIDTH-1:0] idx;
         hist_t                  val;

         assign idx = rd_index[gi*INDEX_WIDTH +: INDEX_WIDTH];

         always_comb begin
            val = spec_reg[idx];
`ifdef BHR_SPEC_BYPASS_EN
            if (flush)
               val = arch_next[idx];
            else if (spec_en && spec_index == idx)
               val = shift_in(spec_reg[idx], spec_taken);
`endif
         end

         assign rd_value[gi*HIST_WIDTH +: HIST_WIDTH] = val;
      end
   endgenerate

endmodule
